// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: picks OFF/FILL/CHASE/BLINK and a step rate from key pulses,
// then steps the active-low 4-LED pattern from an internal divider.
module led_pattern_ctrl #(
  parameter int BASE_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_speed,
  input  logic       run_en,
  output logic [3:0] leds,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       step_tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_FILL  = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [1:0]       speed_q, speed_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       leds_q, leds_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] termVal;
  logic [2:0]       lastStep;
  logic             atTerm;

  function automatic logic [3:0] ledPattern(input mode_e m, input logic [2:0] s);
    logic [3:0] p;
    p = 4'b1111;
    case (m)
      MODE_FILL: begin
        case (s)
          3'd0:    p = 4'b1111;
          3'd1:    p = 4'b1110;
          3'd2:    p = 4'b1100;
          3'd3:    p = 4'b1000;
          3'd4:    p = 4'b0000;
          3'd5:    p = 4'b0001;
          3'd6:    p = 4'b0011;
          default: p = 4'b0111;
        endcase
      end
      MODE_CHASE: begin
        case (s[1:0])
          2'd0:    p = 4'b1110;
          2'd1:    p = 4'b1101;
          2'd2:    p = 4'b1011;
          default: p = 4'b0111;
        endcase
      end
      MODE_BLINK: p = s[0] ? 4'b1111 : 4'b0000;
      default:    p = 4'b1111;
    endcase
    return p;
  endfunction

  // Divider terminal value and the last step index of the current pattern.
  always_comb begin
    termVal  = CNT_W'(BASE_DIV - 1);
    lastStep = 3'd0;
    case (speed_q)
      2'd0:    termVal = CNT_W'(BASE_DIV - 1);
      2'd1:    termVal = CNT_W'((BASE_DIV >> 1) - 1);
      2'd2:    termVal = CNT_W'((BASE_DIV >> 2) - 1);
      default: termVal = CNT_W'((BASE_DIV >> 3) - 1);
    endcase
    case (mode_q)
      MODE_FILL:  lastStep = 3'd7;
      MODE_CHASE: lastStep = 3'd3;
      MODE_BLINK: lastStep = 3'd1;
      default:    lastStep = 3'd0;
    endcase
    atTerm = (cnt_q == termVal);
  end

  // Key pulses take priority over a coinciding terminal count and suppress its tick.
  always_comb begin
    mode_d  = mode_q;
    speed_d = speed_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (key_mode || key_speed) begin
      cnt_d = '0;
      if (key_mode) begin
        mode_d = mode_e'(mode_q + 2'd1);
        step_d = 3'd0;
      end
      if (key_speed) begin
        speed_d = speed_q + 2'd1;
      end
    end else if (run_en && (mode_q != MODE_OFF)) begin
      if (atTerm) begin
        cnt_d  = '0;
        step_d = (step_q == lastStep) ? 3'd0 : step_q + 3'd1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    leds_d = ledPattern(mode_d, step_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      speed_q <= 2'd0;
      step_q  <= 3'd0;
      cnt_q   <= '0;
      leds_q  <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      speed_q <= speed_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      tick_q  <= tick_d;
    end
  end

  assign leds      = leds_q;
  assign mode      = mode_q;
  assign speed     = speed_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios followed by random key/run/reset traffic,
// all compared every cycle against a cycle-count reference model.
module tb_led_pattern_ctrl;

  localparam int BASE_DIV = 16;
  localparam int CNT_W    = 5;

  logic       clk;
  logic       rst;
  logic       keyMode;
  logic       keySpeed;
  logic       runEn;
  logic [3:0] leds;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       stepTick;

  int checks;
  int failures;

  // Reference model state: elapsed cycles since the last step, not a divider image.
  int mMode, mSpeed, mStep, mElapsed;
  bit mTick;

  led_pattern_ctrl #(.BASE_DIV(BASE_DIV), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (keyMode),
    .key_speed(keySpeed),
    .run_en   (runEn),
    .leds     (leds),
    .mode     (mode),
    .speed    (speed),
    .step_tick(stepTick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int periodOf(input int spd);
    return BASE_DIV / (1 << spd);
  endfunction

  function automatic int stepsOf(input int md);
    int n;
    case (md)
      1:       n = 8;
      2:       n = 4;
      3:       n = 2;
      default: n = 1;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] expLeds(input int md, input int st);
    logic [3:0] fillTab [8];
    logic [3:0] r;
    fillTab = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0111};
    r = 4'b1111;
    if (md == 1) r = fillTab[st];
    else if (md == 2) r = ~(4'b0001 << st);
    else if (md == 3) r = (st == 0) ? 4'b0000 : 4'b1111;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelUpdate(input bit km, input bit ks, input bit re, input bit rs);
    mTick = 1'b0;
    if (rs) begin
      mMode = 0; mSpeed = 0; mStep = 0; mElapsed = 0;
    end else if (km || ks) begin
      mElapsed = 0;
      if (km) begin
        mMode = (mMode + 1) % 4;
        mStep = 0;
      end
      if (ks) mSpeed = (mSpeed + 1) % 4;
    end else if (re && mMode != 0) begin
      mElapsed++;
      if (mElapsed == periodOf(mSpeed)) begin
        mElapsed = 0;
        mStep = (mStep + 1) % stepsOf(mMode);
        mTick = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit km, input bit ks, input bit re, input bit rs);
    keyMode  = km;
    keySpeed = ks;
    runEn    = re;
    rst      = rs;
    @(posedge clk);
    modelUpdate(km, ks, re, rs);
    @(negedge clk);
    checkOutput("leds", 32'(leds), 32'(expLeds(mMode, mStep)));
    checkOutput("mode", 32'(mode), 32'(mMode));
    checkOutput("speed", 32'(speed), 32'(mSpeed));
    checkOutput("step_tick", 32'(stepTick), 32'(mTick));
  endtask

  task automatic runIdle(input int n, input bit re);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, re, 1'b0);
  endtask

  // Advance until the next edge would be a terminal count; an expired bound is a failure.
  task automatic waitForTerminal(input string tag);
    int guard;
    guard = 0;
    while (mElapsed != periodOf(mSpeed) - 1 && guard < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    checkOutput(tag, 32'(guard < 200), 32'd1);
  endtask

  initial begin
    int guard;
    checks = 0; failures = 0;
    mMode = 0; mSpeed = 0; mStep = 0; mElapsed = 0; mTick = 1'b0;
    keyMode = 1'b0; keySpeed = 1'b0; runEn = 1'b0; rst = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_leds", 32'(leds), 32'hF);
    runIdle(100, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    runIdle(150, 1'b1);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      runIdle(40, 1'b1);
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    runIdle(21, 1'b1);
    runIdle(40, 1'b0);
    runIdle(60, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    runIdle(20, 1'b1);
    waitForTerminal("wait_blink_term");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("blink_to_off_mode", 32'(mode), 32'd0);
    runIdle(30, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    runIdle(40, 1'b1);
    waitForTerminal("wait_fill_term");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runIdle(20, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    runIdle(20, 1'b1);
    while (mMode != 2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (!(mTick && mStep == 2) && guard < 300) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("wait_chase_step2", 32'(guard < 300), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_tick_clear", 32'(stepTick), 32'd0);
    runIdle(10, 1'b1);

    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 799) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
